equiv_stim_checker: RTL
=======================

Name: equiv_stim_checker

Overview:
- Drives the fuzz design inputs and consumes its wide y result bus; it sits on the opposite side of that interface from the design under test.
- Generates pseudo-random stimulus for two instances of the same fuzz top: the golden RTL and the synthesized/implemented netlist.
- Compares their y buses every cycle and reports pass/fail, first-failure cycle, mismatch count and a response signature.
- Instantiated once per equivalence-identity test harness.

Parameters:
- Y_WIDTH, 284: width of each compared y bus.
- STIM_WIDTH, 25: stimulus bits driven to the design inputs, packed as {wire3, wire2, wire1, wire0}.
- NUM_CYCLES, 1024: number of stimulus cycles per run; minimum 1.
- WARMUP, 4: leading RUN cycles whose compare results are ignored; must be less than NUM_CYCLES.
- SEED, 32'hACE1_2468: initial LFSR value; must be nonzero.

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- stim  out  STIM_WIDTH  stimulus to both DUT instances; low bits of the LFSR
- y_ref  in  Y_WIDTH  golden instance output
- y_dut  in  Y_WIDTH  implementation instance output
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- fail  out  1  sticky; set on any counted mismatch
- first_fail_cycle  out  16  cycle index of the first counted mismatch; 16'hFFFF when none
- mismatch_count  out  16  counted mismatches; saturates at 16'hFFFF
- signature  out  32  MISR over y_dut; 0 when compiled out

Behaviour:
- Reset is synchronous and active-high. On rst:
  - state = IDLE; LFSR = SEED; stim = SEED[STIM_WIDTH-1:0].
  - busy = 0; done = 0; fail = 0; first_fail_cycle = 16'hFFFF; mismatch_count = 0; signature = 0; cycle counter = 0.
- LFSR: 32-bit Galois, taps 32,22,2,1 (mask 32'h8020_0003). Advances one step per RUN cycle only; holds in all other states.
- States:
  - IDLE: stim is held. On start, reload LFSR = SEED, clear all results and the counter, then go to RUN.
  - RUN: each cycle register y_ref and y_dut together with the current cycle index (stage 1), advance the LFSR and counter. When counter == NUM_CYCLES-1, go to DRAIN.
  - DRAIN: one cycle that lets the final stage-1 sample reach compare, then go to DONE.
  - DONE: done = 1 and all results are frozen. A start pulse re-arms exactly as from IDLE.
- Compare stage: one cycle after capture. A mismatch is counted when the registered y_ref != y_dut and the tagged index >= WARMUP.
- On a counted mismatch:
  - fail is set.
  - first_fail_cycle is loaded only if it is still 16'hFFFF.
  - mismatch_count increments unless already saturated.
- Latency: stimulus index k is applied in RUN cycle k; that cycle's y is captured at the end of cycle k and compared in cycle k+1. A run takes NUM_CYCLES + 2 cycles from start to done.
- start is ignored during RUN and DRAIN.
- rst asserted mid-run aborts immediately to reset values. No partial results are retained.
- y values are sampled only in RUN; the inputs are don't-care otherwise.

Optional Feature:
- Macro EQUIV_MISR_EN.
- When defined:
  - signature is a 32-bit MISR, cleared on start.
  - Each stage-1 capture with index >= WARMUP folds y_dut into it, XOR-reduced in 32-bit slices with the top slice zero-padded.
  - Update rule: sig_next = lfsr_step(sig) ^ fold(y_dut).
  - Frozen in DONE.
- When undefined: signature is tied to 0 and no MISR logic is synthesized.

Test Plan:
- Reset, then start with y_dut = y_ref = stim-derived function and NUM_CYCLES = 16 -> done in cycle 18; fail = 0; mismatch_count = 0; first_fail_cycle = 16'hFFFF.
- Force y_dut[0] flipped in RUN cycles 10 and 11 only -> fail = 1; first_fail_cycle = 10; mismatch_count = 2.
- Force a mismatch in RUN cycles 0-3 only with WARMUP = 4 -> fail = 0; mismatch_count = 0.
- Force a permanent mismatch with NUM_CYCLES = 70000 -> mismatch_count = 16'hFFFF (saturated); first_fail_cycle = 4.
- Assert rst at RUN cycle 7, then start again -> stim restarts at the SEED value; counter = 0; results match a clean run.
- With EQUIV_MISR_EN: two runs with identical y -> identical nonzero signature. Flip one bit of y_dut in cycle 5 -> signature differs.

Source files
------------

// File: rtl/equiv_stim_checker.sv
// equiv_stim_checker: LFSR stimulus source and y-bus equivalence checker for golden vs implemented fuzz tops (optional MISR via EQUIV_MISR_EN)
module equiv_stim_checker #(
  parameter int          Y_WIDTH    = 284,
  parameter int          STIM_WIDTH = 25,
  parameter int          NUM_CYCLES = 1024,
  parameter int          WARMUP     = 4,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [STIM_WIDTH-1:0] stim,
  input  logic [Y_WIDTH-1:0]    y_ref,
  input  logic [Y_WIDTH-1:0]    y_dut,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [15:0]           first_fail_cycle,
  output logic [15:0]           mismatch_count,
  output logic [31:0]           signature
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  state_t state, state_n;
  logic [31:0] lfsr, cnt, s1_idx;
  logic [Y_WIDTH-1:0] s1_ref, s1_dut;
  logic s1_valid, go, last, hit;
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? TAPS : 32'h0);
  endfunction
  assign go   = start && (state == IDLE || state == DONE);
  assign last = cnt == 32'(NUM_CYCLES - 1);
  assign hit  = s1_valid && s1_ref != s1_dut && s1_idx >= 32'(WARMUP);
  assign stim = lfsr[STIM_WIDTH-1:0];
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state: start only honoured from IDLE or DONE, RUN lasts NUM_CYCLES, DRAIN one cycle
  always_comb
    state_n = go ? RUN : (state == RUN && last) ? DRAIN : state == DRAIN ? DONE : state;
  // status outputs decoded from state
  always_comb begin
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  // stage-1 capture of both y buses tagged with the cycle index
  always_ff @(posedge clk)
    if (state == RUN) begin
      s1_ref <= y_ref;
      s1_dut <= y_dut;
      s1_idx <= cnt;
    end
  // LFSR, cycle counter and compare-stage result accumulation
  always_ff @(posedge clk)
    if (rst) begin
      lfsr             <= SEED;
      cnt              <= '0;
      s1_valid         <= 1'b0;
      fail             <= 1'b0;
      first_fail_cycle <= 16'hFFFF;
      mismatch_count   <= '0;
    end else begin
      s1_valid <= state == RUN;
      if (go) begin
        lfsr             <= SEED;
        cnt              <= '0;
        fail             <= 1'b0;
        first_fail_cycle <= 16'hFFFF;
        mismatch_count   <= '0;
      end else if (state == RUN) begin
        lfsr <= lfsr_step(lfsr);
        cnt  <= cnt + 32'd1;
      end
      if (hit) begin
        fail <= 1'b1;
        if (first_fail_cycle == 16'hFFFF) first_fail_cycle <= s1_idx[15:0];
        if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
      end
    end
`ifdef EQUIV_MISR_EN
  localparam int SLICES = (Y_WIDTH + 31) / 32;
  logic [SLICES*32-1:0] y_pad;
  logic [31:0] fold, sig;
  // XOR-fold y_dut into one 32-bit word, top slice zero-padded
  always_comb begin
    y_pad = '0;
    y_pad[Y_WIDTH-1:0] = y_dut;
    fold = '0;
    for (int i = 0; i < SLICES; i++) fold = fold ^ y_pad[i*32 +: 32];
  end
  // MISR compacts every post-warmup capture, cleared on start, frozen outside RUN
  always_ff @(posedge clk)
    if (rst || go) sig <= '0;
    else if (state == RUN && cnt >= 32'(WARMUP)) sig <= lfsr_step(sig) ^ fold;
  assign signature = sig;
`else
  assign signature = '0;
`endif
endmodule
